// File: rtl/dp_pkg.sv
// Shared encodings for the parametrised multicycle datapath and its multiplier.
package dp_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_MUL = 3'b100;

   localparam logic [1:0] IMM_B8  = 2'b00;
   localparam logic [1:0] IMM_B12 = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

   localparam logic [1:0] SRCA_A      = 2'b00;
   localparam logic [1:0] SRCA_PC     = 2'b01;
   localparam logic [1:0] SRCA_ALUOUT = 2'b10;

   localparam logic [1:0] SRCB_WD  = 2'b00;
   localparam logic [1:0] SRCB_IMM = 2'b01;
   localparam logic [1:0] SRCB_INC = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_RUN  = 2'b01,
      MUL_DONE = 2'b10
   } mul_state_e;

endpackage

// File: rtl/mc_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles busy,
// then a single done cycle presenting the low WIDTH bits of the product.
module mc_mul_iter
   import dp_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int unsigned CW = $clog2(WIDTH);

   mul_state_e       state_q, state_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MUL_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   // A start is honoured whenever the engine is not iterating (idle or done cycle).
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      case (state_q)
         MUL_IDLE, MUL_DONE: begin
            state_d = MUL_IDLE;
            if (start) begin
               state_d  = MUL_RUN;
               mcand_d  = a;
               mplier_d = b;
               acc_d    = '0;
               cnt_d    = '0;
            end
         end
         MUL_RUN: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = MUL_DONE;
            end
         end
         default: state_d = MUL_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state_q == MUL_RUN);
      done    = (state_q == MUL_DONE);
      product = acc_q;
   end

endmodule

// File: rtl/mc_datapath_param.sv
// Parametrised multicycle ARM-subset datapath with an iterative multiplier;
// all selects/enables come from the external multicycle controller.
module mc_datapath_param
   import dp_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NREGS  = 16,
   parameter int unsigned PC_INC = 4
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] Adr,
   output logic [WIDTH-1:0] WriteData,
   input  logic [WIDTH-1:0] ReadData,
   output logic [WIDTH-1:0] Instr,
   output logic [3:0]       ALUFlags,
   input  logic             PCWrite,
   input  logic             RegWrite,
   input  logic             IRWrite,
   input  logic             AdrSrc,
   input  logic [1:0]       RegSrc,
   input  logic [1:0]       ALUSrcA,
   input  logic [1:0]       ALUSrcB,
   input  logic [1:0]       ResultSrc,
   input  logic [1:0]       ImmSrc,
   input  logic [2:0]       ALUControl,
   input  logic             MulStart,
   output logic             MulBusy,
   output logic             MulDone
);

   localparam int unsigned AW = $clog2(NREGS);

   logic [WIDTH-1:0] pc_q, ir_q, data_q, a_q, wd_q, aluout_q;
   logic [WIDTH-1:0] rf_q [NREGS];
   logic [23:0]      ir24;
   logic [AW-1:0]    ra1, ra2, wa;
   logic [WIDTH-1:0] rd1, rd2, ext_imm, src_a, src_b, result;
   logic [WIDTH-1:0] alu_result, b_eff, mul_product;
   logic [WIDTH:0]   sum;
   logic             is_sub, flag_c, flag_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q     <= '0;
         ir_q     <= '0;
         data_q   <= '0;
         a_q      <= '0;
         wd_q     <= '0;
         aluout_q <= '0;
      end else begin
         if (PCWrite) pc_q <= result;
         if (IRWrite) ir_q <= ReadData;
         data_q <= ReadData;
         a_q    <= rd1;
         wd_q   <= rd2;
         if (!MulBusy) aluout_q <= alu_result;
      end
   end

   // Register file contents are deliberately not reset; the top entry is the PC alias.
   always_ff @(posedge clk) begin
      if (RegWrite && (wa != AW'(NREGS - 1))) begin
         rf_q[wa] <= result;
      end
   end

   always_comb begin
      ir24 = 24'(ir_q);
      ra1  = RegSrc[0] ? AW'(NREGS - 1) : AW'(ir24[19:16]);
      ra2  = RegSrc[1] ? AW'(ir24[15:12]) : AW'(ir24[3:0]);
      wa   = AW'(ir24[15:12]);
      rd1  = (ra1 == AW'(NREGS - 1)) ? result : rf_q[ra1];
      rd2  = (ra2 == AW'(NREGS - 1)) ? result : rf_q[ra2];
   end

   always_comb begin
      ext_imm = '0;
      case (ImmSrc)
         IMM_B8:  ext_imm = WIDTH'(ir24[7:0]);
         IMM_B12: ext_imm = WIDTH'(ir24[11:0]);
         IMM_BR:  ext_imm = WIDTH'({{WIDTH{ir24[23]}}, ir24, 2'b00});
         default: ext_imm = '0;
      endcase
   end

   always_comb begin
      src_a = a_q;
      case (ALUSrcA)
         SRCA_PC:     src_a = pc_q;
         SRCA_ALUOUT: src_a = aluout_q;
         default:     src_a = a_q;
      endcase
      src_b = wd_q;
      case (ALUSrcB)
         SRCB_IMM: src_b = ext_imm;
         SRCB_INC: src_b = WIDTH'(PC_INC);
         default:  src_b = wd_q;
      endcase
   end

   mc_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (MulStart && (ALUControl == ALU_MUL)),
      .a       (src_a),
      .b       (src_b),
      .busy    (MulBusy),
      .done    (MulDone),
      .product (mul_product)
   );

   // SUB is A + ~B + 1 so carry-out means "no borrow".
   always_comb begin
      is_sub     = (ALUControl == ALU_SUB);
      b_eff      = is_sub ? ~src_b : src_b;
      sum        = {1'b0, src_a} + {1'b0, b_eff} + (WIDTH + 1)'(is_sub);
      alu_result = '0;
      flag_c     = 1'b0;
      flag_v     = 1'b0;
      case (ALUControl)
         ALU_ADD, ALU_SUB: begin
            alu_result = sum[WIDTH-1:0];
            flag_c     = sum[WIDTH];
            flag_v     = (src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         ALU_AND: alu_result = src_a & src_b;
         ALU_ORR: alu_result = src_a | src_b;
         ALU_MUL: alu_result = MulDone ? mul_product : '0;
         default: alu_result = '0;
      endcase
      ALUFlags = {alu_result[WIDTH-1], (alu_result == '0), flag_c, flag_v};
   end

   always_comb begin
      result = aluout_q;
      case (ResultSrc)
         RES_DATA: result = data_q;
         RES_ALU:  result = alu_result;
         default:  result = aluout_q;
      endcase
      Adr       = AdrSrc ? result : pc_q;
      WriteData = wd_q;
      Instr     = ir_q;
   end

endmodule

// File: tb/tb_mc_datapath_param.sv
// Directed bench for mc_datapath_param: a 32-bit/16-reg instance and a 16-bit/8-reg
// instance share one control stream; expected values are hand-computed constants.
module tb_mc_datapath_param;

   logic        clk;
   logic        reset;
   logic        PCWrite, RegWrite, IRWrite, AdrSrc, MulStart;
   logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
   logic [2:0]  ALUControl;
   logic [31:0] ReadData;

   logic [31:0] Adr, WriteData, Instr;
   logic [3:0]  ALUFlags;
   logic        MulBusy, MulDone;

   logic [15:0] s_Adr, s_WriteData, s_Instr;
   logic [3:0]  s_ALUFlags;
   logic        s_MulBusy, s_MulDone;

   int total;
   int bad;

   mc_datapath_param #(.WIDTH(32), .NREGS(16), .PC_INC(4)) dut (
      .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
      .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
   );

   mc_datapath_param #(.WIDTH(16), .NREGS(8), .PC_INC(4)) dut_s (
      .clk(clk), .reset(reset), .Adr(s_Adr), .WriteData(s_WriteData),
      .ReadData(ReadData[15:0]), .Instr(s_Instr), .ALUFlags(s_ALUFlags),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
      .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
      .ImmSrc(ImmSrc), .ALUControl(ALUControl), .MulStart(MulStart),
      .MulBusy(s_MulBusy), .MulDone(s_MulDone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl_idle();
      PCWrite = 1'b0; RegWrite = 1'b0; IRWrite = 1'b0; AdrSrc = 1'b0; MulStart = 1'b0;
      RegSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b00;
      ImmSrc = 2'b00; ALUControl = 3'b000;
   endtask

   // PC <- pcv through the Data register, IR <- irv in the same cycle.
   task automatic load_pc_ir(input logic [31:0] pcv, input logic [31:0] irv);
      ctl_idle();
      ReadData = pcv;
      cyc();
      PCWrite = 1'b1; IRWrite = 1'b1; ResultSrc = 2'b01; ReadData = irv;
      cyc();
      ctl_idle();
   endtask

   // PC + ExtImm(Instr[7:0]) with the ALU result on Adr.
   task automatic alu_setup(input logic [2:0] op);
      ALUSrcA = 2'b01; ALUSrcB = 2'b01; ImmSrc = 2'b00; ResultSrc = 2'b10;
      AdrSrc = 1'b1; ALUControl = op;
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      ctl_idle();
      reset    = 1'b1;
      ReadData = 32'h0;
      cyc();
      cyc();
      chk("rst_pc", Adr, 32'h0);
      chk("rst_ir", Instr, 32'h0);
      chk("rst_busy", 32'(MulBusy), 32'h0);
      chk("rst_done", 32'(MulDone), 32'h0);
      chk("s_rst_pc", 32'(s_Adr), 32'h0);
      chk("s_rst_ir", 32'(s_Instr), 32'h0);
      AdrSrc = 1'b1;
      #1;
      chk("rst_aluout", Adr, 32'h0);
      reset = 1'b0;
      ctl_idle();

      // Fetch twice: PC 0 -> 4 -> 8
      ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      PCWrite = 1'b1; IRWrite = 1'b1; ReadData = 32'hE2811005;
      #1;
      chk("fetch_adr", Adr, 32'h0);
      cyc();
      chk("fetch_ir", Instr, 32'hE2811005);
      chk("fetch_pc", Adr, 32'h4);
      chk("s_fetch_ir", 32'(s_Instr), 32'h1005);
      chk("s_fetch_pc", 32'(s_Adr), 32'h4);
      cyc();
      chk("fetch2_pc", Adr, 32'h8);
      chk("s_fetch2_pc", 32'(s_Adr), 32'h8);

      // Decode: RA1 = PC alias returns Result (8+4)
      PCWrite = 1'b0; IRWrite = 1'b0; RegSrc = 2'b01; AdrSrc = 1'b1;
      #1;
      chk("dec_result", Adr, 32'd12);
      cyc();
      RegSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b01; ImmSrc = 2'b00;
      ALUControl = 3'b000; ResultSrc = 2'b10; AdrSrc = 1'b1;
      #1;
      chk("ra1_alias", Adr, 32'd17);
      chk("s_ra1_alias", 32'(s_Adr), 32'd17);
      ALUSrcA = 2'b01; ImmSrc = 2'b10;
      #1;
      chk("imm_branch", Adr, 32'hFE04401C);
      chk("s_imm_branch", 32'(s_Adr), 32'h401C);
      ImmSrc = 2'b01;
      #1;
      chk("imm_12", Adr, 32'd13);

      // Register write to R1 = PC+4, then read back through RA2 = Instr[15:12]
      ALUSrcB = 2'b10; ImmSrc = 2'b00; RegWrite = 1'b1; AdrSrc = 1'b0;
      cyc();
      RegWrite = 1'b0; RegSrc = 2'b10;
      cyc();
      chk("rf_wd", WriteData, 32'd12);
      chk("s_rf_wd", 32'(s_WriteData), 32'd12);

      // ALU and flags {N,Z,C,V}
      load_pc_ir(32'h7FFFFFFF, 32'h1);
      alu_setup(3'b000);
      chk("add_ovf_res", Adr, 32'h80000000);
      chk("add_ovf_flags", 32'(ALUFlags), 32'h9);
      alu_setup(3'b010);
      chk("and_res", Adr, 32'h1);
      chk("and_flags", 32'(ALUFlags), 32'h0);
      alu_setup(3'b011);
      chk("orr_res", Adr, 32'h7FFFFFFF);
      alu_setup(3'b001);
      chk("sub_res", Adr, 32'h7FFFFFFE);
      chk("sub_flags", 32'(ALUFlags), 32'h2);

      load_pc_ir(32'd5, 32'd5);
      alu_setup(3'b001);
      chk("sub_zero_res", Adr, 32'h0);
      chk("sub_zero_flags", 32'(ALUFlags), 32'h6);
      alu_setup(3'b000);
      chk("add_small", Adr, 32'd10);
      chk("add_small_flags", 32'(ALUFlags), 32'h0);

      load_pc_ir(32'hFFFFFFFF, 32'h1);
      alu_setup(3'b000);
      chk("add_carry_res", Adr, 32'h0);
      chk("add_carry_flags", 32'(ALUFlags), 32'h6);
      alu_setup(3'b001);
      chk("sub_neg_flags", 32'(ALUFlags), 32'hA);

      load_pc_ir(32'd5, 32'd6);
      alu_setup(3'b001);
      chk("sub_borrow_res", Adr, 32'hFFFFFFFF);
      chk("sub_borrow_flags", 32'(ALUFlags), 32'h8);

      // Multiply 7*6; restart attempt at k+10 must be ignored
      load_pc_ir(32'd7, 32'd6);
      alu_setup(3'b100);
      chk("mul_nodone_res", Adr, 32'h0);
      chk("mul_nodone_flags", 32'(ALUFlags), 32'h4);
      ResultSrc = 2'b00;
      MulStart  = 1'b1;
      cyc();
      for (int i = 1; i <= 40; i++) begin
         MulStart = (i == 10);
         chk("mul_busy", 32'(MulBusy), 32'(i <= 32));
         chk("mul_done", 32'(MulDone), 32'(i == 33));
         chk("s_mul_busy", 32'(s_MulBusy), 32'(i <= 16));
         chk("s_mul_done", 32'(s_MulDone), 32'(i == 17));
         if (i == 32) chk("mul_busy_flags", 32'(ALUFlags), 32'h4);
         if (i == 33) chk("mul_done_flags", 32'(ALUFlags), 32'h0);
         if (i == 17) chk("s_mul_done_flags", 32'(s_ALUFlags), 32'h0);
         if (i == 34) chk("mul_aluout", Adr, 32'd42);
         if (i == 18) chk("s_mul_aluout", 32'(s_Adr), 32'd42);
         cyc();
      end
      MulStart = 1'b0;

      // Reset during a multiply: abort with no done pulse
      MulStart = 1'b1;
      cyc();
      MulStart = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         reset = (i == 5);
         chk("rmul_busy", 32'(MulBusy), 32'(i <= 5));
         chk("rmul_done", 32'(MulDone), 32'h0);
         chk("s_rmul_busy", 32'(s_MulBusy), 32'(i <= 5));
         chk("s_rmul_done", 32'(s_MulDone), 32'h0);
         if (i == 6) chk("rmul_aluout", Adr, 32'h0);
         cyc();
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
